preamble_generator: RTL

Transmit-side counterpart of the receiver's STS correlator. On a start pulse it streams the OFDM preamble as 16-bit two's-complement I/Q samples through a valid/ready interface: NUM_STS_REP repetitions of the 16-sample short training symbol (STS), then the long training field (32-sample guard interval plus two 64-sample LTS).
It sits ahead of the TX DAC/IFFT output mux. STS coefficients are held internally; LTS samples come from an external combinational ROM.

---
 rtl/preamble_generator.sv | 138 +++++++++++++
 1 files changed

// File: rtl/preamble_generator.sv
// OFDM transmit preamble source: NUM_STS_REP short training symbols followed by
// the long training field (32-sample guard + 2x64 LTS), streamed over valid/ready.
module preamble_generator #(
  parameter int NUM_STS_REP = 10,
  parameter bit WINDOW      = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Out_Ready,
  input  logic [15:0] LTS_Real,
  input  logic [15:0] LTS_Imag,
  output logic [5:0]  LTS_Addr,
  output logic [15:0] Out_Real,
  output logic [15:0] Out_Imag,
  output logic        OutputEnable,
  output logic        Sts_Flag,
  output logic        Busy,
  output logic        Done,
  output logic [2:0]  State_Dbg
);

  // Handshake: a sample moves when OutputEnable && Out_Ready at a rising Clk;
  // while Out_Ready is low every output register and counter holds its value.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STS    = 3'd1,
    S_LTS_GI = 3'd2,
    S_LTS    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [8:0] STS_LEN = 9'(16 * NUM_STS_REP);
  localparam logic [8:0] GI_END  = STS_LEN + 9'd32;
  localparam logic [8:0] TOTAL   = STS_LEN + 9'd160;

  localparam logic signed [15:0] STS_RE [16] = '{
    16'sd377, -16'sd1081, -16'sd106, 16'sd1171, 16'sd754, 16'sd1171, -16'sd106, -16'sd1081,
    16'sd377, 16'sd16, -16'sd647, -16'sd106, 16'sd0, -16'sd106, -16'sd647, 16'sd16
  };
  localparam logic signed [15:0] STS_IM [16] = '{
    16'sd377, 16'sd16, -16'sd647, -16'sd106, 16'sd0, -16'sd106, -16'sd647, 16'sd16,
    16'sd377, -16'sd1081, -16'sd106, 16'sd1171, 16'sd754, 16'sd1171, -16'sd106, -16'sd1081
  };

  state_t      state_q, state_d;
  logic [8:0]  idx_q, idx_d;      // index of the next sample to load
  logic [15:0] re_q, re_d;
  logic [15:0] im_q, im_d;
  logic        oe_q, oe_d;

  logic [15:0] sample_re, sample_im;
  logic [15:0] first_re, first_im;
  state_t      field;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      re_q    <= re_d;
      im_q    <= im_d;
      oe_q    <= oe_d;
    end
  end

  // LTS_GI starts at ROM address 32, so one modulo-64 offset covers GI and both LTS copies.
  always_comb begin
    LTS_Addr = 6'd0;
    if (idx_q >= STS_LEN) LTS_Addr = idx_q[5:0] - STS_LEN[5:0] + 6'd32;
  end

  always_comb begin
    first_re  = WINDOW ? 16'(STS_RE[0] >>> 1) : STS_RE[0];
    first_im  = WINDOW ? 16'(STS_IM[0] >>> 1) : STS_IM[0];
    sample_re = LTS_Real;
    sample_im = LTS_Imag;
    if (idx_q < STS_LEN) begin
      sample_re = STS_RE[idx_q[3:0]];
      sample_im = STS_IM[idx_q[3:0]];
    end
    if (idx_q < STS_LEN)     field = S_STS;
    else if (idx_q < GI_END) field = S_LTS_GI;
    else                     field = S_LTS;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    re_d    = re_q;
    im_d    = im_q;
    oe_d    = oe_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          re_d    = first_re;
          im_d    = first_im;
          oe_d    = 1'b1;
          idx_d   = 9'd1;
          state_d = S_STS;
        end
      end
      S_STS, S_LTS_GI, S_LTS: begin
        if (Out_Ready) begin
          if (idx_q == TOTAL) begin
            re_d    = '0;
            im_d    = '0;
            oe_d    = 1'b0;
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            re_d    = sample_re;
            im_d    = sample_im;
            idx_d   = idx_q + 9'd1;
            state_d = field;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign Out_Real     = re_q;
  assign Out_Imag     = im_q;
  assign OutputEnable = oe_q;
  assign Sts_Flag     = (state_q == S_STS);
  assign Busy         = (state_q == S_STS) || (state_q == S_LTS_GI) || (state_q == S_LTS);
  assign Done         = (state_q == S_DONE);
  assign State_Dbg    = state_q;

endmodule
